// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC sequencer with run/halt/single-step debug control
// Optional breakpoint compare is enabled by defining PC_BREAKPOINT_EN.
module pc_sequencer #(
    parameter int                     PC_WIDTH     = 7,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0,
    parameter bit                     START_HALTED = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                halt_req,
    input  logic                step_req,
    input  logic                resume_req,
    input  logic                bp_valid,
    input  logic [PC_WIDTH-1:0] bp_addr,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus1,
    output logic                fetch_valid,
    output logic                halted,
    output logic                step_done,
    output logic                bp_hit
);

    typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP} state_t;

    localparam state_t RESET_STATE = START_HALTED ? S_HALT : S_RUN;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_step_done;
    logic                w_bp_match;
    logic                w_adv;
    logic [PC_WIDTH-1:0] w_pc_inc;

    assign w_pc_inc = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};

    // rst_n gates the qualifier so nothing is consumed while reset is held
    assign w_adv = rst_n & !stall &
                   (((r_state == S_RUN) & !halt_req & !w_bp_match) | (r_state == S_STEP));

`ifdef PC_BREAKPOINT_EN
    logic r_suppress;
    logic r_bp_hit;

    assign w_bp_match = (r_state == S_RUN) & bp_valid & (r_pc == bp_addr) & !r_suppress;

    // Suppression survives until the first real fetch after HALT, so a stalled
    // first cycle cannot re-trigger the breakpoint that just halted us.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_suppress <= 1'b1;
            r_bp_hit   <= 1'b0;
        end else begin
            r_bp_hit <= !stall & !halt_req & w_bp_match;
            if (r_state == S_HALT)
                r_suppress <= 1'b1;
            else if (w_adv)
                r_suppress <= 1'b0;
        end
    end

    assign bp_hit = r_bp_hit;
`else
    logic w_unused_bp;

    assign w_unused_bp = bp_valid ^ (^bp_addr);
    assign w_bp_match  = 1'b0;
    assign bp_hit      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RESET_STATE;
            r_pc        <= RESET_VECTOR;
            r_step_done <= 1'b0;
        end else begin
            r_step_done <= (r_state == S_STEP) & !stall;
            if (w_adv) begin
                if (jump)
                    r_pc <= jump_target;
                else if (branch_taken)
                    r_pc <= branch_target;
                else
                    r_pc <= w_pc_inc;
            end
            if (!stall) begin
                case (r_state)
                    S_RUN: begin
                        if (halt_req || w_bp_match)
                            r_state <= S_HALT;
                    end
                    S_HALT: begin
                        if (step_req)
                            r_state <= S_STEP;
                        else if (resume_req)
                            r_state <= S_RUN;
                    end
                    S_STEP:  r_state <= S_HALT;
                    default: r_state <= S_HALT;
                endcase
            end
        end
    end

    assign pc          = r_pc;
    assign pc_plus1    = w_pc_inc;
    assign fetch_valid = w_adv;
    assign halted      = (r_state == S_HALT);
    assign step_done   = r_step_done;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage controller owning the program counter register. Each cycle it selects the next fetch address from sequential increment, branch target or jump target. It holds the PC under hazard stalls and implements a debug run/halt/single-step state machine. It drives the instruction-memory address and the valid qualifier for the IF/ID pipeline register.

## Interface
- PC_WIDTH, 7, width of every address port and of the PC register
- RESET_VECTOR, 7'd0, PC value loaded on reset
- START_HALTED, 0, 1 = leave reset in HALT, 0 = leave reset in RUN

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  hazard unit hold request; PC and state hold while high
- branch_taken  in  1  redirect to branch_target
- branch_target  in  PC_WIDTH  branch destination
- jump  in  1  redirect to jump_target
- jump_target  in  PC_WIDTH  jump destination
- halt_req  in  1  debug halt request, level
- step_req  in  1  debug single-step request, sampled in HALT only
- resume_req  in  1  debug resume request, sampled in HALT only
- bp_valid  in  1  breakpoint enable (used only with PC_BREAKPOINT_EN)
- bp_addr  in  PC_WIDTH  breakpoint address (used only with PC_BREAKPOINT_EN)
- pc  out  PC_WIDTH  current fetch address (registered)
- pc_plus1  out  PC_WIDTH  pc+1 mod 2^PC_WIDTH, combinational, forwarded down the pipe
- fetch_valid  out  1  instruction at pc is consumed this cycle
- halted  out  1  state == HALT
- step_done  out  1  one-cycle pulse after a step completes
- bp_hit  out  1  one-cycle pulse on breakpoint halt

## Operation
- States: RUN, HALT, STEP. Encoding is free; only `halted` is visible.
- Advance condition: `adv = fetch_valid`. `fetch_valid = (RUN & !halt_req & !bp_match) | (STEP & !stall)`, gated by `!stall` in RUN as well.
- Next PC when adv: jump → jump_target; else branch_taken → branch_target; else pc+1. Increment wraps 2^PC_WIDTH−1 → 0.
- No advance: PC holds. Redirects presented while stall or HALT are ignored. The requester holds them until accepted.
- RUN:
  - halt_req=1 → HALT. PC holds, fetch_valid=0, even if stall=0.
  - bp_match → HALT, bp_hit=1 next cycle.
  - Otherwise stay.
- HALT:
  - step_req → STEP.
  - Else resume_req → RUN.
  - step_req and resume_req together: step wins.
  - halt_req is ignored in HALT.
- STEP:
  - stall=1 → stay in STEP.
  - Else advance once → HALT, step_done=1 the following cycle.
  - halt_req is ignored in STEP.
- Breakpoint suppression: the first RUN or STEP cycle after leaving HALT ignores bp_match, so resume/step from a breakpoint makes progress.
- bp_match = bp_valid & (pc == bp_addr), evaluated in RUN only.

## Timing
- Reset (rst_n=0, asynchronous):
  - pc = RESET_VECTOR
  - state = HALT if START_HALTED, else RUN
  - step_done = 0, bp_hit = 0, suppression flag set
- Outputs during reset: fetch_valid=0; halted = START_HALTED.
- Deassertion is taken at the next clk edge. Reset mid-step discards the step with no step_done.
- pc changes exactly one edge after a cycle with adv=1. Redirect latency is 1 cycle.
- pc_plus1 and fetch_valid are combinational from registers and inputs. halted, step_done and bp_hit are registered.
- Step latency: step_req at edge N → STEP in cycle N+1 → fetch at N+1 (no stall) → HALT and step_done=1 in cycle N+2.

## Configuration
- PC_BREAKPOINT_EN defined: breakpoint compare, bp_hit and suppression flag are implemented as above.
- Undefined: bp_match is constant 0, bp_valid/bp_addr are ignored, bp_hit is tied 0. Ports remain, so instantiations are unchanged.

## Test plan
- Reset with START_HALTED=0, no stimulus, 130 cycles → pc 0,1,…,127,0,1. fetch_valid=1 throughout. pc_plus1 at pc=127 is 0.
- At pc=5 assert stall 3 cycles, with branch_taken=1/target=40 during the stall and the cycle after → pc stays 5 for 3 cycles, then 40. Drive jump=1/target=9 together with branch → jump wins, pc=9.
- At pc=12 assert halt_req 1 cycle → halted=1, pc stays 12, fetch_valid=0. Then step_req → pc 13, step_done pulse, halted=1. Then step_req+resume_req together → step wins, pc 14, still halted.
- In STEP hold stall=1 for 2 cycles → pc unchanged, no step_done. Release → pc+1, step_done one cycle later.
- With PC_BREAKPOINT_EN, bp_valid=1, bp_addr=20, running from 0 → halt with pc=20, fetch_valid=0 at 20, bp_hit pulse. resume_req → pc 21 next (no re-hit). Without macro → runs through 20, bp_hit=0.
- Pull rst_n low mid-STEP with pc=33 → pc=RESET_VECTOR immediately (before clk edge), step_done never pulses.
